// File: rtl/lin_transform.sv
// -----------------------------------------------------------------------------
// lin_transform
//   Grasshopper linear layer L (and optionally L^-1) over GF(2^8), reduction
//   polynomial x^8+x^7+x^6+x+1 (0x1C3). A block is taken through 16 R steps,
//   STEPS of them per clock, so a block finishes 16/STEPS clocks after it is
//   accepted. Holds exactly one block; no internal buffering.
//
// Parameters
//   STEPS     R steps per clock: 1, 2, 4, 8 or 16 (anything else fails
//             elaboration)
//
// Configuration macro
//   LIN_INVERSE_EN  when defined, adds inv_i and the R^-1 datapath so the same
//                   stage can also compute L^-1 with identical latency.
//
// Ports
//   clk       in   1    clock, rising edge
//   rst       in   1    asynchronous active-high reset (release synchronously)
//   valid_i   in   1    data_i holds a block
//   ready_o   out  1    stage can accept a block (follows ready_i when DONE)
//   data_i    in   128  input block, a15 = [127:120] .. a0 = [7:0]
//   inv_i     in   1    (LIN_INVERSE_EN only) 1 = L^-1, sampled on accept
//   valid_o   out  1    data_o holds a finished block
//   ready_i   in   1    downstream takes data_o
//   data_o    out  128  transformed block
// -----------------------------------------------------------------------------
module lin_transform #(
    parameter int STEPS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
`ifdef LIN_INVERSE_EN
    input  logic         inv_i,
`endif
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] data_o
);

    generate
        if (!(STEPS == 1 || STEPS == 2 || STEPS == 4 || STEPS == 8 || STEPS == 16)) begin : g_bad_steps
            $error("lin_transform: STEPS must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // GF(2^8) arithmetic
    // -------------------------------------------------------------------------
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        // multiply by x, folding x^8 back as x^7+x^6+x+1
        return {a[6:0], 1'b0} ^ (a[7] ? 8'hC3 : 8'h00);
    endfunction

    // Shift-and-reduce multiply; with a constant k the unused branches fold away.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) begin
                acc = acc ^ p;
            end
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] mul_16 (input logic [7:0] a); return gf_mul_const(a, 8'd16);  endfunction
    function automatic logic [7:0] mul_32 (input logic [7:0] a); return gf_mul_const(a, 8'd32);  endfunction
    function automatic logic [7:0] mul_133(input logic [7:0] a); return gf_mul_const(a, 8'd133); endfunction
    function automatic logic [7:0] mul_148(input logic [7:0] a); return gf_mul_const(a, 8'd148); endfunction
    function automatic logic [7:0] mul_192(input logic [7:0] a); return gf_mul_const(a, 8'd192); endfunction
    function automatic logic [7:0] mul_194(input logic [7:0] a); return gf_mul_const(a, 8'd194); endfunction
    function automatic logic [7:0] mul_251(input logic [7:0] a); return gf_mul_const(a, 8'd251); endfunction

    // Linear functional l over the 16 bytes (a15 in the top byte).
    function automatic logic [7:0] l_fn(input logic [127:0] a);
        return mul_148(a[127:120]) ^ mul_32 (a[119:112]) ^ mul_133(a[111:104]) ^ mul_16 (a[103:96])
             ^ mul_194(a[95:88])   ^ mul_192(a[87:80])   ^ a[79:72]            ^ mul_251(a[71:64])
             ^ a[63:56]            ^ mul_192(a[55:48])   ^ mul_194(a[47:40])   ^ mul_16 (a[39:32])
             ^ mul_133(a[31:24])   ^ mul_32 (a[23:16])   ^ mul_148(a[15:8])    ^ a[7:0];
    endfunction

    // R: shift right one byte, l of the old block enters at the top.
    function automatic logic [127:0] rstep_fwd(input logic [127:0] a);
        return {l_fn(a), a[127:8]};
    endfunction

`ifdef LIN_INVERSE_EN
    // R^-1: shift left one byte; the bottom byte is recovered by evaluating l
    // on the block rotated left by one byte (a0 has coefficient 1, so this
    // cancels every other term of the forward l).
    function automatic logic [127:0] rstep_inv(input logic [127:0] a);
        return {a[119:0], l_fn({a[119:0], a[127:120]})};
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] CNT_STEP = 5'(STEPS);
    localparam logic [4:0] CNT_LAST = 5'd16;

    state_t       r_state;
    state_t       w_state_next;
    logic [4:0]   r_cnt;
    logic [127:0] r_work;
    logic [127:0] r_data_o;
    logic [4:0]   w_cnt_inc;
    logic         w_accept;
    logic         w_finish;
    logic [127:0] w_step_result;
`ifdef LIN_INVERSE_EN
    logic         r_inv_flag;
`endif

    assign w_cnt_inc = r_cnt + CNT_STEP;
    assign w_finish  = (r_state == S_BUSY) && (w_cnt_inc == CNT_LAST);
    assign w_accept  = valid_i & ready_o;
    assign data_o    = r_data_o;

    // STEPS rounds of R unrolled combinationally on the working block.
    always_comb begin
        w_step_result = r_work;
        for (int i = 0; i < STEPS; i++) begin
`ifdef LIN_INVERSE_EN
            w_step_result = r_inv_flag ? rstep_inv(w_step_result) : rstep_fwd(w_step_result);
`else
            w_step_result = rstep_fwd(w_step_result);
`endif
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_cnt_inc == CNT_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // a block offered while the result drains is taken in the same cycle
                if (ready_i) begin
                    w_state_next = valid_i ? S_BUSY : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (r_state)
            S_IDLE: ready_o = 1'b1;
            S_DONE: begin
                ready_o = ready_i;
                valid_o = 1'b1;
            end
            default: begin
                ready_o = 1'b0;
                valid_o = 1'b0;
            end
        endcase
        // nothing may be accepted while reset is held
        if (rst) begin
            ready_o = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: work register, step counter, result register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work   <= '0;
            r_cnt    <= '0;
            r_data_o <= '0;
`ifdef LIN_INVERSE_EN
            r_inv_flag <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_work <= data_i;
                r_cnt  <= '0;
`ifdef LIN_INVERSE_EN
                r_inv_flag <= inv_i;
`endif
            end else if (r_state == S_BUSY) begin
                r_work <= w_step_result;
                r_cnt  <= w_cnt_inc;
                // result register only ever sees a completed block
                if (w_finish) begin
                    r_data_o <= w_step_result;
                end
            end
        end
    end

endmodule
